// File: rtl/can_error_frame_gen.sv
// CAN error-frame generator: on any monitor error drives flag, recessive wait,
// delimiter and intermission onto o_Tx, timed by the bit-sample tick.
module can_error_frame_gen #(
  parameter int FLAG_BITS     = 6,
  parameter int DELIM_BITS    = 8,
  parameter int INTER_BITS    = 3,
  parameter int MAX_WAIT_BITS = 7
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Bit_Tick,
  input  logic       i_Data,
  input  logic       i_form_monitor,
  input  logic       i_bit_error,
  input  logic       i_stuff_error,
  input  logic       i_crc_error,
  input  logic       i_ack_error,
  input  logic       i_error_passive,
  output logic       o_Tx,
  output logic       o_error_active,
  output logic [4:0] o_error_code,
  output logic       o_frame_done,
  output logic       o_bus_stuck,
  output logic [7:0] o_error_count
);

  typedef enum logic [2:0] {IDLE, PENDING, FLAG, WAIT_REC, DELIM, INTER} state_t;

  localparam logic [7:0] FLAG_LAST = 8'(FLAG_BITS - 1);
  localparam logic [7:0] DELIM_N   = 8'(DELIM_BITS);
  localparam logic [7:0] INTER_N   = 8'(INTER_BITS);
  localparam logic [7:0] WAIT_N    = 8'(MAX_WAIT_BITS);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;     // one counter serves bit/wait/del/int counts
  logic [7:0] count_q, count_d;
  logic [4:0] code_q, code_d;
  logic       tx_q, tx_d;
  logic       act_q, act_d;
  logic       done_q, done_d;
  logic       stuck_q, stuck_d;
  logic [4:0] errs;
  logic [7:0] cnt_inc;

  assign errs    = {i_form_monitor, i_bit_error, i_stuff_error, i_crc_error, i_ack_error};
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    code_d  = code_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    stuck_d = 1'b0;
    case (state_q)
      IDLE: if (|errs) begin
        state_d = PENDING;
        code_d  = errs;
      end
      PENDING: if (i_Bit_Tick) begin
        state_d = FLAG;
        cnt_d   = 8'd0;
        tx_d    = i_error_passive;
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
      end
      FLAG: if (i_Bit_Tick) begin
        if (cnt_q == FLAG_LAST) begin
          state_d = WAIT_REC;
          cnt_d   = 8'd0;
          tx_d    = 1'b1;
        end else cnt_d = cnt_inc;
      end
      WAIT_REC: if (i_Bit_Tick) begin
        if (i_Data) begin
          state_d = DELIM;
          cnt_d   = 8'd1;
        end else if (cnt_inc == WAIT_N) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          stuck_d = 1'b1;
        end else cnt_d = cnt_inc;
      end
      DELIM: if (i_Bit_Tick) begin
        if (i_Data) begin
          if (cnt_inc == DELIM_N) begin
            state_d = INTER;
            cnt_d   = 8'd0;
          end else cnt_d = cnt_inc;
        end else begin
          // dominant inside the delimiter is a bit error: restart the flag
          state_d = FLAG;
          cnt_d   = 8'd0;
          code_d  = 5'b01000;
          tx_d    = i_error_passive;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
      end
      INTER: if (i_Bit_Tick) begin
        if (cnt_inc == INTER_N) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
        end else cnt_d = cnt_inc;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        tx_d    = 1'b1;
      end
    endcase
    act_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      count_q <= 8'd0;
      code_q  <= 5'd0;
      tx_q    <= 1'b1;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      code_q  <= code_d;
      tx_q    <= tx_d;
      act_q   <= act_d;
      done_q  <= done_d;
      stuck_q <= stuck_d;
    end
  end

  assign o_Tx           = tx_q;
  assign o_error_active = act_q;
  assign o_error_code   = code_q;
  assign o_frame_done   = done_q;
  assign o_bus_stuck    = stuck_q;
  assign o_error_count  = count_q;

endmodule

// File: tb/tb_can_error_frame_gen.sv
// Directed bench for can_error_frame_gen: normal, passive, superposed,
// stuck-bus, delimiter bit-error and mid-frame reset scenarios.
module tb_can_error_frame_gen;
  logic       clk = 1'b0;
  logic       rst_n, tick_i, data_i;
  logic       form_i, bit_i, stuff_i, crc_i, ack_i, passive_i;
  logic       tx, active, done, stuck;
  logic [4:0] code;
  logic [7:0] ecount;

  int tests = 0;
  int fails = 0;
  logic saw_done, saw_stuck;

  can_error_frame_gen dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Bit_Tick(tick_i), .i_Data(data_i),
    .i_form_monitor(form_i), .i_bit_error(bit_i), .i_stuff_error(stuff_i),
    .i_crc_error(crc_i), .i_ack_error(ack_i), .i_error_passive(passive_i),
    .o_Tx(tx), .o_error_active(active), .o_error_code(code),
    .o_frame_done(done), .o_bus_stuck(stuck), .o_error_count(ecount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // one bit tick with bus level d; pulse outputs captured right after the edge
  task automatic tick(input logic d);
    data_i = d; tick_i = 1'b1;
    @(posedge clk); #1;
    tick_i = 1'b0;
    saw_done = done; saw_stuck = stuck;
    @(posedge clk); #1;
  endtask

  // PENDING->FLAG tick plus the six flag ticks with the bus echoing o_Tx
  task automatic run_flag(output int ndom);
    ndom = 0;
    tick(1'b1);
    if (tx == 1'b0) ndom++;
    for (int i = 0; i < 6; i++) begin
      tick(tx);
      if (tx == 1'b0) ndom++;
    end
  endtask

  task automatic run_rec(output int n, output logic got_done, output logic got_stuck);
    n = 0; got_done = 1'b0; got_stuck = 1'b0;
    while (!got_done && !got_stuck && n < 20) begin
      tick(1'b1);
      n++;
      got_done = saw_done; got_stuck = saw_stuck;
    end
  endtask

  int   nd, nr;
  logic gd, gs;

  initial begin
    rst_n = 1'b0; tick_i = 1'b0; data_i = 1'b1; passive_i = 1'b0;
    form_i = 1'b0; bit_i = 1'b0; stuff_i = 1'b0; crc_i = 1'b0; ack_i = 1'b0;
    step(); step();
    chk("reset_tx", tx, 1);
    chk("reset_active", active, 0);
    chk("reset_code", code, 0);
    chk("reset_count", ecount, 0);
    chk("reset_pulses", {done, stuck}, 0);
    rst_n = 1'b1;
    step();

    // 1: form error held 3 clocks, active flag
    form_i = 1'b1; step(); step(); step(); form_i = 1'b0;
    chk("s1_code", code, 5'b10000);
    chk("s1_active", active, 1);
    chk("s1_tx_pending", tx, 1);
    run_flag(nd);
    chk("s1_dom_ticks", nd, 6);
    chk("s1_tx_after_flag", tx, 1);
    chk("s1_count", ecount, 1);
    run_rec(nr, gd, gs);
    chk("s1_rec_ticks", nr, 11);
    chk("s1_done_stuck", {gd, gs}, 2'b10);
    chk("s1_idle", active, 0);
    chk("s1_done_one_clk", done, 0);

    // 2: passive node, CRC error
    passive_i = 1'b1;
    crc_i = 1'b1; step(); crc_i = 1'b0;
    chk("s2_code", code, 5'b00010);
    run_flag(nd);
    chk("s2_dom_ticks", nd, 0);
    passive_i = 1'b0;
    run_rec(nr, gd, gs);
    chk("s2_rec_ticks", nr, 11);
    chk("s2_done_stuck", {gd, gs}, 2'b10);
    chk("s2_count", ecount, 2);

    // 3: superposed flags, 3 extra dominant bits
    bit_i = 1'b1; step(); bit_i = 1'b0;
    chk("s3_code", code, 5'b01000);
    run_flag(nd);
    chk("s3_dom_ticks", nd, 6);
    gs = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(1'b0); gs |= saw_stuck; end
    chk("s3_no_stuck_wait", gs, 0);
    chk("s3_active_wait", active, 1);
    run_rec(nr, gd, gs);
    chk("s3_rec_ticks", nr, 11);
    chk("s3_done_stuck", {gd, gs}, 2'b10);
    chk("s3_count", ecount, 3);

    // 4: bus stuck dominant
    ack_i = 1'b1; step(); ack_i = 1'b0;
    run_flag(nd);
    gs = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(1'b0); gs |= saw_stuck; end
    chk("s4_no_stuck_early", gs, 0);
    chk("s4_active_6", active, 1);
    tick(1'b0);
    chk("s4_stuck", saw_stuck, 1);
    chk("s4_stuck_one_clk", stuck, 0);
    chk("s4_idle", active, 0);
    gd = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(1'b1); gd |= saw_done; end
    chk("s4_no_done", gd, 0);
    chk("s4_count", ecount, 4);

    // 5: dominant on 4th delimiter bit restarts the flag
    stuff_i = 1'b1; step(); stuff_i = 1'b0;
    chk("s5_code_first", code, 5'b00100);
    run_flag(nd);
    chk("s5_count_first", ecount, 5);
    tick(1'b1); tick(1'b1); tick(1'b1);
    chk("s5_tx_delim", tx, 1);
    tick(1'b0);
    chk("s5_code_restart", code, 5'b01000);
    chk("s5_tx_restart", tx, 0);
    chk("s5_count_restart", ecount, 6);
    nd = 1;
    for (int i = 0; i < 6; i++) begin
      tick(tx);
      if (tx == 1'b0) nd++;
    end
    chk("s5_dom_ticks", nd, 6);
    run_rec(nr, gd, gs);
    chk("s5_rec_ticks", nr, 11);

    // 6: asynchronous reset during flag bit 3
    ack_i = 1'b1; step(); ack_i = 1'b0;
    tick(1'b1);
    tick(1'b0); tick(1'b0);
    chk("s6_tx_in_flag", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_tx", tx, 1);
    chk("s6_rst_active", active, 0);
    chk("s6_rst_count", ecount, 0);
    chk("s6_rst_code", code, 0);
    step(); rst_n = 1'b1; step();
    ack_i = 1'b1; step(); ack_i = 1'b0;
    chk("s6_code", code, 5'b00001);
    run_flag(nd);
    chk("s6_dom_ticks", nd, 6);
    run_rec(nr, gd, gs);
    chk("s6_rec_ticks", nr, 11);
    chk("s6_done_stuck", {gd, gs}, 2'b10);
    chk("s6_count", ecount, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/can_error_frame_gen.md
Name: can_error_frame_gen

Overview:
- Downstream consumer of the CAN error monitors: the form monitor plus the bit, stuff, CRC and ACK monitors.
- On any error indication it drives an error frame onto the transmit line: an error flag, a recessive wait, an error delimiter, then intermission.
- Reports when the bus is free again, so the frame-field decoder can resynchronise.
- All bus timing is driven by the bit-rate tick from the bit-timing block.

Parameters:
- FLAG_BITS, 6: length of the error flag in bits.
- DELIM_BITS, 8: number of consecutive recessive bits in the error delimiter.
- INTER_BITS, 3: intermission length in bits.
- MAX_WAIT_BITS, 7: maximum dominant bits tolerated after the flag (superposed flags from other nodes) before declaring the bus stuck.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  asynchronous reset, active low.
- i_Bit_Tick  in  1  one-cycle pulse at the bit sample point.
- i_Data  in  1  sampled bus level (1 = recessive).
- i_form_monitor  in  1  form error (may stay high for several clocks).
- i_bit_error  in  1  bit error.
- i_stuff_error  in  1  stuff error.
- i_crc_error  in  1  CRC error.
- i_ack_error  in  1  ACK error.
- i_error_passive  in  1  node is error-passive (flag is recessive).
- o_Tx  out  1  bus drive bit (1 = recessive).
- o_error_active  out  1  high whenever state is not IDLE.
- o_error_code  out  5  captured sources, bit order {form, bit, stuff, crc, ack}.
- o_frame_done  out  1  one-clock pulse when intermission completes.
- o_bus_stuck  out  1  one-clock pulse on wait timeout.
- o_error_count  out  8  saturating count of error flags started.

Behaviour:
- Reset (asynchronous, active low):
  - state = IDLE, o_Tx = 1, o_error_code = 0, o_error_count = 0.
  - All pulses low; bit counters 0.
- IDLE:
  - Errors are sampled every clock.
  - Any error input high → PENDING next clock; o_error_code = the 5 inputs sampled in that cycle.
  - Error inputs are ignored in every state except IDLE.
- PENDING: on i_Bit_Tick → FLAG; bit_cnt = 0; o_error_count += 1, saturating at 255.
  - o_Tx = 0 if active, 1 if i_error_passive.
  - i_error_passive is sampled at the transition into FLAG.
- FLAG:
  - Each tick increments bit_cnt.
  - On the tick where bit_cnt == FLAG_BITS-1 → WAIT_REC; o_Tx = 1; wait_cnt = 0.
- WAIT_REC, on tick:
  - i_Data == 1 → DELIM with del_cnt = 1.
  - Otherwise wait_cnt++; if wait_cnt reaches MAX_WAIT_BITS → o_bus_stuck pulse and go to IDLE.
- DELIM, on tick:
  - i_Data == 1 → del_cnt++; reaching DELIM_BITS → INTER with int_cnt = 0.
  - i_Data == 0 → counts as a bit error: o_error_code = 5'b01000, return directly to FLAG (bit_cnt = 0, count++, o_Tx per passive rule).
  - o_Tx = 1 throughout.
- INTER:
  - o_Tx = 1; each tick int_cnt++.
  - When int_cnt reaches INTER_BITS → IDLE; o_frame_done pulses in the same clock as the transition.
- Outputs:
  - All outputs are registered; o_Tx changes in the clock after the tick that causes the transition.
  - o_error_code holds its value until the next capture.
- Timing rules:
  - An error and a tick in the same clock: go to PENDING only; the flag starts at the following tick (minimum 1 bit latency).
  - A tick with no state change does not alter o_Tx.
  - Counters never exceed their parameter limit.
- Reset asserted mid-frame: immediately returns to reset values, o_Tx = 1.

Test Plan:
- i_form_monitor high for 3 clocks between ticks, bus echoes o_Tx, then recessive:
  - o_error_code = 5'b10000.
  - o_Tx = 0 for exactly 6 ticks, then 1.
  - o_frame_done pulses after 8 + 3 = 11 further ticks (first recessive tick included in the delimiter).
  - o_error_count = 1.
- i_error_passive = 1 with an i_crc_error pulse:
  - o_Tx stays 1 throughout.
  - o_error_code = 5'b00010.
  - Sequence lengths identical to the first scenario.
- Bus held dominant 3 extra bits after the flag (superposition):
  - DELIM entered on the 4th tick after the flag ends.
  - o_frame_done follows 10 ticks after DELIM entry.
  - No o_bus_stuck.
- Bus held dominant 7 ticks after the flag:
  - o_bus_stuck pulses once; state returns to IDLE; o_frame_done never pulses.
- Dominant sampled on the 4th delimiter bit:
  - New flag starts; o_error_code = 5'b01000; o_error_count increments to 2.
- Assert i_Reset_n low during FLAG bit 3:
  - o_Tx = 1 and o_error_active = 0 within the same clock (asynchronous).
  - o_error_count = 0.
  - A subsequent i_ack_error produces a normal full sequence.
